actigraphy_epoch_scheduler: RTL and testbench

- Sequences the actigraphy count datapath: generates the 50 Hz sample tick and fetches one z-axis sample per tick from the accelerometer reader over a req/ack handshake.
- Forwards each sample to the count datapath as a one-cycle valid strobe and holds the datapath in reset while disabled.
- Accumulates the datapath's 15 s counts into fixed epochs and presents each epoch to the storage/host side on a valid/ready interface.
- Sits between the accelerometer SPI reader, the count datapath and the epoch log memory.

---
 rtl/actigraphy_epoch_scheduler_pkg.sv | 17 +
 rtl/actigraphy_epoch_scheduler_epoch_accumulator.sv | 64 ++++++
 rtl/actigraphy_epoch_scheduler.sv | 130 +++++++++++++
 tb/tb_actigraphy_epoch_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/actigraphy_epoch_scheduler_pkg.sv
// Shared types and helpers for the actigraphy epoch scheduler.
// Holds the FSM state encoding and the epoch saturation function.
package actigraphy_epoch_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    REQUEST
  } state_t;

  function automatic logic [7:0] sat_u10_to_u8(
    input logic [9:0] v
  );
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/actigraphy_epoch_scheduler_epoch_accumulator.sv
// Sums datapath counts into epochs and presents them on valid/ready.
// A newer epoch always replaces an unaccepted one and flags overrun.
module epoch_accumulator
  import actigraphy_epoch_scheduler_pkg::*;
#(
  parameter int EPOCH_COUNTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] count,
  input  logic       count_valid,
  output logic [7:0] epoch,
  output logic       epoch_valid,
  input  logic       epoch_ready,
  output logic       overrun
);

  localparam int IW = 3;

  logic [9:0]    acc;
  logic [9:0]    total;
  logic [IW-1:0] idx;
  logic          last;
  logic          load;
  logic          accept;

  assign total  = acc + 10'(count);
  assign last   = (idx == IW'(EPOCH_COUNTS - 1));
  assign load   = run && count_valid && last;
  assign accept = epoch_valid && epoch_ready;

  // Leaving the run state drops any partial epoch.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      acc <= '0;
      idx <= '0;
    end else if (count_valid) begin
      if (last) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= total;
        idx <= idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epoch       <= '0;
      epoch_valid <= 1'b0;
      overrun     <= 1'b0;
    end else if (load) begin
      epoch       <= sat_u10_to_u8(total);
      epoch_valid <= 1'b1;
      if (epoch_valid && !epoch_ready)
        overrun <= 1'b1;
    end else if (accept) begin
      epoch_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/actigraphy_epoch_scheduler.sv
// Sample-tick sequencer for the actigraphy count datapath.
// Fetches one z sample per tick and hands counts to the epoch stage.
module actigraphy_epoch_scheduler
  import actigraphy_epoch_scheduler_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 240000,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int EPOCH_COUNTS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_enable,
  output logic       o_accel_req,
  input  logic       i_accel_ack,
  input  logic [7:0] i_accel_data,
  output logic       o_datapath_reset,
  output logic [7:0] o_sample,
  output logic       o_sample_valid,
  input  logic [7:0] i_count,
  input  logic       i_count_valid,
  output logic [7:0] o_epoch,
  output logic       o_epoch_valid,
  input  logic       i_epoch_ready,
  output logic       o_timeout,
  output logic       o_overrun
);

  localparam int TW = $clog2(CLKS_PER_SAMPLE);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] tick;
  logic [OW-1:0] to_cnt;
  logic [7:0]    last_sample;
  logic          tick_done;
  logic          to_done;
  logic          in_req;
  logic          ack_hit;
  logic          to_hit;
  logic          run;

  assign run       = (state != IDLE) && i_enable;
  assign tick_done = (tick == TW'(CLKS_PER_SAMPLE - 1));
  assign to_done   = (to_cnt == OW'(TIMEOUT_CYCLES - 1));
  assign in_req    = (state == REQUEST) && i_enable;
  assign ack_hit   = in_req && i_accel_ack;
  assign to_hit    = in_req && !i_accel_ack && to_done;

  assign o_accel_req      = in_req && !reset;
  assign o_datapath_reset = reset || !i_enable;
  assign o_sample         = last_sample;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_enable)
          state_n = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!i_enable)
          state_n = IDLE;
        else if (tick_done)
          state_n = REQUEST;
      end
      REQUEST: begin
        if (!i_enable)
          state_n = IDLE;
        else if (i_accel_ack || to_done)
          state_n = WAIT_TICK;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Free-running outside IDLE so ack latency never stretches the period.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE)
      tick <= '0;
    else if (tick_done)
      tick <= '0;
    else
      tick <= tick + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || state != REQUEST)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + OW'(1);
  end

  // A missed ack replays the previous sample to hold the rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_sample    <= '0;
      o_sample_valid <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_sample_valid <= ack_hit || to_hit;
      if (ack_hit)
        last_sample <= i_accel_data;
      if (to_hit)
        o_timeout <= 1'b1;
    end
  end

  epoch_accumulator #(
    .EPOCH_COUNTS(EPOCH_COUNTS)
  ) u_epoch (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .count      (i_count),
    .count_valid(i_count_valid),
    .epoch      (o_epoch),
    .epoch_valid(o_epoch_valid),
    .epoch_ready(i_epoch_ready),
    .overrun    (o_overrun)
  );

endmodule

// File: tb/tb_actigraphy_epoch_scheduler.sv
// Directed/random bench for actigraphy_epoch_scheduler.
// Expected values come from tick arithmetic and an epoch sum model.
module tb_actigraphy_epoch_scheduler;

  localparam int CLKS = 20;
  localparam int TMO  = 4;
  localparam int EPC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_enable;
  logic       o_accel_req;
  logic       i_accel_ack;
  logic [7:0] i_accel_data;
  logic       o_datapath_reset;
  logic [7:0] o_sample;
  logic       o_sample_valid;
  logic [7:0] i_count;
  logic       i_count_valid;
  logic [7:0] o_epoch;
  logic       o_epoch_valid;
  logic       i_epoch_ready;
  logic       o_timeout;
  logic       o_overrun;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int next_req    = 0;

  actigraphy_epoch_scheduler #(
    .CLKS_PER_SAMPLE(CLKS),
    .TIMEOUT_CYCLES (TMO),
    .EPOCH_COUNTS   (EPC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_enable        (i_enable),
    .o_accel_req     (o_accel_req),
    .i_accel_ack     (i_accel_ack),
    .i_accel_data    (i_accel_data),
    .o_datapath_reset(o_datapath_reset),
    .o_sample        (o_sample),
    .o_sample_valid  (o_sample_valid),
    .i_count         (i_count),
    .i_count_valid   (i_count_valid),
    .o_epoch         (o_epoch),
    .o_epoch_valid   (o_epoch_valid),
    .i_epoch_ready   (i_epoch_ready),
    .o_timeout       (o_timeout),
    .o_overrun       (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_epoch(input int a,
                                             input int b);
    int s;
    s = a + b;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  task automatic wait_req(output int rc);
    int n;
    n = 0;
    while (o_accel_req !== 1'b1 && n < 2 * CLKS) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", o_accel_req, 1);
    rc = cyc;
  endtask

  // lat > TMO means the reader never answers this tick.
  task automatic do_tick(input int lat,
                         input logic [7:0] d,
                         input logic [7:0] exp_s,
                         input logic exp_to);
    int rc;
    wait_req(rc);
    check("req_time", rc, next_req);
    next_req += CLKS;
    for (int k = 1; k <= TMO; k++) begin
      check("req_held", o_accel_req, 1);
      i_accel_ack  = (k == lat);
      i_accel_data = d;
      @(posedge clk);
      #1 i_accel_ack = 1'b0;
      if (k == lat || k == TMO) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("smp_valid", o_sample_valid, 1);
    check("smp_data", o_sample, exp_s);
    check("req_drop", o_accel_req, 0);
    check("timeout", o_timeout, exp_to);
    @(negedge clk);
    check("smp_pulse", o_sample_valid, 0);
  endtask

  task automatic send_count(input logic [7:0] c,
                            input int gap);
    repeat (gap) @(negedge clk);
    i_count       = c;
    i_count_valid = 1'b1;
    @(negedge clk);
    i_count_valid = 1'b0;
  endtask

  task automatic epoch_pair(input int a, input int b,
                            input logic ov);
    send_count(8'(a), $urandom_range(0, 4));
    send_count(8'(b), $urandom_range(0, 4));
    check("ep_valid", o_epoch_valid, 1);
    check("ep_value", o_epoch, model_epoch(a, b));
    check("overrun", o_overrun, ov);
  endtask

  task automatic accept();
    i_epoch_ready = 1'b1;
    @(negedge clk);
    i_epoch_ready = 1'b0;
    check("ep_accept", o_epoch_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed hang expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int a;
    int b;
    reset         = 1'b1;
    i_enable      = 1'b0;
    i_accel_ack   = 1'b0;
    i_accel_data  = '0;
    i_count       = '0;
    i_count_valid = 1'b0;
    i_epoch_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dpr", o_datapath_reset, 1);
    check("rst_req", o_accel_req, 0);
    check("rst_sv", o_sample_valid, 0);
    check("rst_smp", o_sample, 0);
    check("rst_ev", o_epoch_valid, 0);
    check("rst_ep", o_epoch, 0);
    check("rst_to", o_timeout, 0);
    check("rst_ov", o_overrun, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_dpr", o_datapath_reset, 1);

    i_enable = 1'b1;
    #1 check("en_dpr", o_datapath_reset, 0);
    next_req = cyc + 1 + CLKS;
    do_tick(3, 8'd5, 8'd5, 1'b0);
    repeat (3) begin
      d = 8'($urandom);
      do_tick($urandom_range(1, 3), d, d, 1'b0);
    end
    d = 8'($urandom);
    do_tick(TMO, d, d, 1'b0);
    do_tick($urandom_range(1, 3), 8'hF9, 8'hF9, 1'b0);

    repeat (2) @(negedge clk);
    i_accel_ack  = 1'b1;
    i_accel_data = 8'h33;
    @(negedge clk);
    i_accel_ack = 1'b0;
    check("stray_sv", o_sample_valid, 0);
    do_tick(TMO + 10, 8'h00, 8'hF9, 1'b1);
    d = 8'($urandom);
    do_tick($urandom_range(1, 3), d, d, 1'b1);

    epoch_pair(100, 50, 1'b0);
    accept();
    epoch_pair(200, 200, 1'b0);
    accept();
    repeat (4) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      epoch_pair(a, b, 1'b0);
      accept();
    end

    epoch_pair($urandom_range(0, 255), 7, 1'b0);
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    send_count(8'(a), 1);
    i_epoch_ready = 1'b1;
    send_count(8'(b), 0);
    i_epoch_ready = 1'b0;
    check("acc_ld_v", o_epoch_valid, 1);
    check("acc_ld_e", o_epoch, model_epoch(a, b));
    check("acc_ld_ov", o_overrun, 0);
    accept();

    epoch_pair(10, 20, 1'b0);
    epoch_pair(15, 25, 1'b1);
    accept();

    send_count(8'd80, 1);
    i_enable = 1'b0;
    #1 check("dis_dpr", o_datapath_reset, 1);
    check("dis_req", o_accel_req, 0);
    repeat (3) @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    epoch_pair(10, 20, 1'b1);
    check("to_sticky", o_timeout, 1);
    accept();

    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    epoch_pair(a, b, 1'b1);
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_v", o_epoch_valid, 1);
    check("hold_e", o_epoch, model_epoch(a, b));

    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_ev", o_epoch_valid, 0);
    check("mrst_ep", o_epoch, 0);
    check("mrst_ov", o_overrun, 0);
    check("mrst_to", o_timeout, 0);
    check("mrst_dpr", o_datapath_reset, 1);
    check("mrst_req", o_accel_req, 0);
    reset = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
